pdp8_mem_responder: RTL and testbench
=====================================

// Module: pdp8_mem_responder
// PURPOSE
//  Memory-side responder for the PDP-8 instruction-fetch and execute ports: 4096x12 word store.
//  Answers single-cycle ifu_rd_req pulses from the IFD with ifu_rd_data/ifu_rd_valid.
//  Serves EXEC read/write requests on the same single-port array.
//  Sits between the IFD/EXEC units and the array; sole owner of memory contents.
// PARAMETERS
//  ADDR_WIDTH    12    word address width (`ADDR_WIDTH)
//  DATA_WIDTH    12    word width (`DATA_WIDTH)
//  MEM_DEPTH     4096  words; address used modulo MEM_DEPTH
//  READ_LATENCY  1     cycles from accepted read to valid data; legal 1..4
// PORTS
//  clk            in   1   clock, all logic on posedge
//  reset_n        in   1   reset, asynchronous, active-high
//  ifu_rd_req     in   1   IFD fetch request, single-cycle pulse
//  ifu_rd_addr    in   12  fetch address, sampled with ifu_rd_req
//  ifu_rd_data    out  12  fetched word, held until next IFD read returns
//  ifu_rd_valid   out  1   one-cycle pulse, ifu_rd_data valid
//  exec_rd_req    in   1   EXEC operand read pulse
//  exec_rd_addr   in   12  operand address
//  exec_rd_data   out  12  operand word, held until next EXEC read returns
//  exec_rd_valid  out  1   one-cycle pulse
//  exec_wr_req    in   1   EXEC write pulse
//  exec_wr_addr   in   12  write address
//  exec_wr_data   in   12  write data
//  exec_wr_ack    out  1   one-cycle pulse, cycle after the write commits
//  mem_busy       out  1   any request pending or in the read pipe
//  mem_ovf        out  1   sticky: request arrived while same port already pending
//  mem_par_err    out  1   parity error pulse (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, pending flags cleared, pipe flushed, FSM=IDLE; array NOT cleared.
//  Reset mid-operation: in-flight reads dropped, no valid/ack emitted for them.
//  Each port has a 1-deep pending register capturing addr(+data) on its req pulse.
//  One array access per cycle. Fixed priority: exec_wr > exec_rd > ifu_rd.
//  Uncontended read: accepted on req edge; valid pulse exactly READ_LATENCY cycles later.
//  Loser stays pending, served in priority order in following cycles; order within a port is kept.
//  Same-cycle write+read, same address: write first; read served next cycle and returns new data.
//  Req on a port whose pending slot is full: new req dropped, mem_ovf set until reset.
//  FSM: IDLE  -> SERVE on any req.
//       SERVE -> BACKLOG when more than one request is outstanding.
//       BACKLOG -> SERVE when one remains; SERVE -> IDLE when none remain and the pipe is empty.
//  Read pipe: READ_LATENCY stages carrying {port_id, data}; valid routed by port_id.
//  Address width exact: no wrap logic beyond modulo MEM_DEPTH index truncation.
// CONFIGURATION
//  MEM_PARITY_EN defined: array stores 13 bits {even parity, data}.
//    Parity is written on every write and checked on every read.
//    Mismatch -> mem_par_err pulses with the read's valid; data is still returned.
//  MEM_PARITY_EN undefined: 12-bit array; mem_par_err tied 0; port kept.
// STRUCTURE
//  pdp8_pkg additions:
//    mem_port_e {PORT_IFU, PORT_EXEC_RD, PORT_EXEC_WR}
//    mem_req_s {valid, addr, data}
//    resp_state_e {IDLE, SERVE, BACKLOG}
//  Sub-module mem_rd_pipe: parameterised READ_LATENCY shift pipe of {port_id, data, par_err}.
//  Array: behavioural reg array; bench preloads via hierarchical $readmemh.
// TESTING
//  1. Preload [0o200]=0o7402. ifu_rd_req@0o200 -> ifu_rd_valid 1 cycle later, data 0o7402.
//  2. Same cycle: exec_wr 0o300<=0o1234 and ifu_rd 0o300 -> wr_ack next cycle; ifu data 0o1234, one cycle later than uncontended.
//  3. All three reqs in one cycle -> order wr, exec_rd, ifu_rd; FSM visits BACKLOG; mem_busy drops after last valid.
//  4. Two ifu_rd_req on consecutive cycles while EXEC write pending -> second accepted once the slot frees; no mem_ovf.
//  5. ifu_rd_req twice while slot full -> mem_ovf=1 and stays 1 until reset_n.
//  6. reset_n during in-flight read with READ_LATENCY=3 -> no valid pulse; array value survives; parity flip (MEM_PARITY_EN) -> mem_par_err with valid.

Source files
------------

// File: rtl/pdp8_pkg.sv
// rtl/pdp8_pkg.sv - shared types and slot helper for the PDP-8 memory responder
package pdp8_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;

  typedef enum logic [1:0] {PORT_IFU, PORT_EXEC_RD, PORT_EXEC_WR} mem_port_e;
  typedef enum logic [1:0] {IDLE, SERVE, BACKLOG} resp_state_e;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } mem_req_s;

  typedef struct packed {
    logic                  valid;
    mem_port_e             port;
    logic [DATA_WIDTH-1:0] data;
    logic                  par_err;
  } rd_entry_s;

  // A slot served this cycle may reload from a same-cycle pulse, so back-to-back requests survive.
  function automatic mem_req_s slot_next(input mem_req_s              slot,
                                         input logic                  req,
                                         input logic [ADDR_WIDTH-1:0] addr,
                                         input logic [DATA_WIDTH-1:0] data,
                                         input logic                  served);
    mem_req_s incoming;
    incoming.valid = req;
    incoming.addr  = addr;
    incoming.data  = data;
    if (served)          slot_next = slot.valid ? incoming : '0;
    else if (slot.valid) slot_next = slot;
    else                 slot_next = incoming;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - READ_LATENCY-deep shift pipe carrying {port_id, data, par_err}
module mem_rd_pipe
  import pdp8_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic      clk,
  input  logic      reset_n,
  input  rd_entry_s in_entry,
  output rd_entry_s out_entry,
  output logic      busy
);

  rd_entry_s stage_q [READ_LATENCY];

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_entry;
      for (int i = 1; i < READ_LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++) busy = busy | stage_q[i].valid;
  end

  assign out_entry = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/pdp8_mem_responder.sv
// rtl/pdp8_mem_responder.sv - 4096x12 single-port store serving IFD fetch and EXEC read/write
// Optional MEM_PARITY_EN: array holds {even parity, data} and flags mismatches on read.
module pdp8_mem_responder
  import pdp8_pkg::*;
#(
  parameter int MEM_DEPTH    = 4096,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_valid,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_valid,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_ack,
  output logic                  mem_busy,
  output logic                  mem_ovf,
  output logic                  mem_par_err
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
`ifdef MEM_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif

  logic [WORD_W-1:0]     mem [MEM_DEPTH];
  mem_req_s              ifu_q, erd_q, ewr_q;
  mem_req_s              ifu_eff, erd_eff, ewr_eff, sel;
  logic                  serve_wr, serve_erd, serve_ifu, overflow;
  logic [IDX_W-1:0]      idx;
  logic [WORD_W-1:0]     rd_word, wr_word;
  logic [1:0]            n_eff;
  rd_entry_s             pipe_in, pipe_out;
  logic                  pipe_busy, wr_ack_q, ovf_q;
  logic [DATA_WIDTH-1:0] ifu_hold_q, erd_hold_q;
  resp_state_e           state, state_next;

  // A held request always wins over a new pulse on the same port, keeping per-port order.
  always_comb begin
    if (ifu_q.valid) ifu_eff = ifu_q;
    else ifu_eff = '{valid: ifu_rd_req, addr: ifu_rd_addr, data: '0};
    if (erd_q.valid) erd_eff = erd_q;
    else erd_eff = '{valid: exec_rd_req, addr: exec_rd_addr, data: '0};
    if (ewr_q.valid) ewr_eff = ewr_q;
    else ewr_eff = '{valid: exec_wr_req, addr: exec_wr_addr, data: exec_wr_data};

    serve_wr  = ewr_eff.valid;
    serve_erd = erd_eff.valid && !serve_wr;
    serve_ifu = ifu_eff.valid && !serve_wr && !erd_eff.valid;
    sel       = serve_wr ? ewr_eff : (serve_erd ? erd_eff : ifu_eff);
    idx       = sel.addr[IDX_W-1:0];
    n_eff     = {1'b0, ifu_eff.valid} + {1'b0, erd_eff.valid} + {1'b0, ewr_eff.valid};
    overflow  = (ifu_q.valid && ifu_rd_req && !serve_ifu) ||
                (erd_q.valid && exec_rd_req && !serve_erd) ||
                (ewr_q.valid && exec_wr_req && !serve_wr);

    rd_word       = mem[idx];
    pipe_in.valid = serve_erd || serve_ifu;
    pipe_in.port  = serve_erd ? PORT_EXEC_RD : PORT_IFU;
    pipe_in.data  = rd_word[DATA_WIDTH-1:0];
`ifdef MEM_PARITY_EN
    wr_word         = {^sel.data, sel.data};
    pipe_in.par_err = ^rd_word;
`else
    wr_word         = sel.data;
    pipe_in.par_err = 1'b0;
`endif
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!reset_n && serve_wr) mem[idx] <= wr_word;
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      ifu_q      <= '0;
      erd_q      <= '0;
      ewr_q      <= '0;
      wr_ack_q   <= 1'b0;
      ovf_q      <= 1'b0;
      ifu_hold_q <= '0;
      erd_hold_q <= '0;
    end else begin
      ifu_q    <= slot_next(ifu_q, ifu_rd_req, ifu_rd_addr, '0, serve_ifu);
      erd_q    <= slot_next(erd_q, exec_rd_req, exec_rd_addr, '0, serve_erd);
      ewr_q    <= slot_next(ewr_q, exec_wr_req, exec_wr_addr, exec_wr_data, serve_wr);
      wr_ack_q <= serve_wr;
      if (overflow)      ovf_q      <= 1'b1;
      if (ifu_rd_valid)  ifu_hold_q <= pipe_out.data;
      if (exec_rd_valid) erd_hold_q <= pipe_out.data;
    end
  end

  mem_rd_pipe #(.READ_LATENCY(READ_LATENCY)) u_rd_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_entry  (pipe_in),
    .out_entry (pipe_out),
    .busy      (pipe_busy)
  );

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (n_eff != 2'd0) state_next = SERVE;
      SERVE: begin
        if (n_eff > 2'd1)                      state_next = BACKLOG;
        else if (n_eff == 2'd0 && !pipe_busy) state_next = IDLE;
      end
      BACKLOG: if (n_eff <= 2'd1) state_next = SERVE;
      default: state_next = IDLE;
    endcase
  end

  assign ifu_rd_valid  = pipe_out.valid && (pipe_out.port == PORT_IFU);
  assign exec_rd_valid = pipe_out.valid && (pipe_out.port == PORT_EXEC_RD);
  assign ifu_rd_data   = ifu_rd_valid ? pipe_out.data : ifu_hold_q;
  assign exec_rd_data  = exec_rd_valid ? pipe_out.data : erd_hold_q;
  assign exec_wr_ack   = wr_ack_q;
  assign mem_busy      = ifu_q.valid || erd_q.valid || ewr_q.valid || pipe_busy;
  assign mem_ovf       = ovf_q;
  assign mem_par_err   = pipe_out.valid && pipe_out.par_err;

endmodule

// File: tb/tb_pdp8_mem_responder.sv
// tb/tb_pdp8_mem_responder.sv - directed bench: latency-1 responder plus latency-3 instance
module tb_pdp8_mem_responder;
  import pdp8_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        ifu_rd_req, exec_rd_req, exec_wr_req;
  logic [11:0] ifu_rd_addr, exec_rd_addr, exec_wr_addr, exec_wr_data;
  logic [11:0] ifu_rd_data, exec_rd_data;
  logic        ifu_rd_valid, exec_rd_valid, exec_wr_ack, mem_busy, mem_ovf, mem_par_err;

  logic        l3_ifu_req, l3_erd_req, l3_ewr_req;
  logic [11:0] l3_ifu_addr, l3_erd_addr, l3_ewr_addr, l3_ewr_data;
  logic [11:0] l3_ifu_data, l3_erd_data;
  logic        l3_ifu_valid, l3_erd_valid, l3_ewr_ack, l3_busy, l3_ovf, l3_par_err;

  int tests = 0;
  int fails = 0;

  pdp8_mem_responder dut (
    .clk(clk), .reset_n(reset_n),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_data(ifu_rd_data), .ifu_rd_valid(ifu_rd_valid),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr),
    .exec_rd_data(exec_rd_data), .exec_rd_valid(exec_rd_valid),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr),
    .exec_wr_data(exec_wr_data), .exec_wr_ack(exec_wr_ack),
    .mem_busy(mem_busy), .mem_ovf(mem_ovf), .mem_par_err(mem_par_err)
  );

  pdp8_mem_responder #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .ifu_rd_req(l3_ifu_req), .ifu_rd_addr(l3_ifu_addr),
    .ifu_rd_data(l3_ifu_data), .ifu_rd_valid(l3_ifu_valid),
    .exec_rd_req(l3_erd_req), .exec_rd_addr(l3_erd_addr),
    .exec_rd_data(l3_erd_data), .exec_rd_valid(l3_erd_valid),
    .exec_wr_req(l3_ewr_req), .exec_wr_addr(l3_ewr_addr),
    .exec_wr_data(l3_ewr_data), .exec_wr_ack(l3_ewr_ack),
    .mem_busy(l3_busy), .mem_ovf(l3_ovf), .mem_par_err(l3_par_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_rd_req = 0; exec_rd_req = 0; exec_wr_req = 0;
    ifu_rd_addr = 0; exec_rd_addr = 0; exec_wr_addr = 0; exec_wr_data = 0;
    l3_ifu_req = 0; l3_erd_req = 0; l3_ewr_req = 0;
    l3_ifu_addr = 0; l3_erd_addr = 0; l3_ewr_addr = 0; l3_ewr_data = 0;
  endtask

  task automatic wr1(input logic [11:0] a, input logic [11:0] d);
    exec_wr_req = 1; exec_wr_addr = a; exec_wr_data = d;
    tick();
    exec_wr_req = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1;
    repeat (3) tick();
    tests++;
    if ({ifu_rd_valid, exec_rd_valid, exec_wr_ack, mem_busy, mem_ovf, mem_par_err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 000000",
               {ifu_rd_valid, exec_rd_valid, exec_wr_ack, mem_busy, mem_ovf, mem_par_err});
    end
    tests++;
    if ({ifu_rd_data, exec_rd_data} !== 24'h0) begin
      fails++; $display("FAIL reset_data got %o/%o want 0/0", ifu_rd_data, exec_rd_data);
    end
    tests++;
    if (dut.state !== IDLE) begin
      fails++; $display("FAIL reset_state got %0d want IDLE", dut.state);
    end
    tests++;
    if ({l3_ifu_valid, l3_erd_valid, l3_ewr_ack, l3_busy, l3_ovf, l3_par_err} !== 6'b0) begin
      fails++; $display("FAIL reset_flags_l3 got %b want 000000",
                        {l3_ifu_valid, l3_erd_valid, l3_ewr_ack, l3_busy, l3_ovf, l3_par_err});
    end
    reset_n = 0;
    tick();
  endtask

  task automatic test_uncontended();
    wr1(12'o200, 12'o7402);
    tests++;
    if (exec_wr_ack !== 1'b1) begin fails++; $display("FAIL t1_wr_ack got %b want 1", exec_wr_ack); end
    ifu_rd_req = 1; ifu_rd_addr = 12'o200;
    tick();
    ifu_rd_req = 0;
    tests++;
    if (ifu_rd_valid !== 1'b1) begin fails++; $display("FAIL t1_ifu_valid got %b want 1", ifu_rd_valid); end
    tests++;
    if (ifu_rd_data !== 12'o7402) begin fails++; $display("FAIL t1_ifu_data got %o want 7402", ifu_rd_data); end
    tests++;
    if ({exec_rd_valid, mem_par_err} !== 2'b00) begin
      fails++; $display("FAIL t1_other_pulses got %b want 00", {exec_rd_valid, mem_par_err});
    end
    tick();
    tests++;
    if ({ifu_rd_valid, mem_busy} !== 2'b00) begin
      fails++; $display("FAIL t1_after got valid,busy=%b want 00", {ifu_rd_valid, mem_busy});
    end
    tests++;
    if (ifu_rd_data !== 12'o7402) begin fails++; $display("FAIL t1_ifu_hold got %o want 7402", ifu_rd_data); end
    exec_rd_req = 1; exec_rd_addr = 12'o200;
    tick();
    exec_rd_req = 0;
    tests++;
    if ({exec_rd_valid, exec_rd_data} !== {1'b1, 12'o7402}) begin
      fails++; $display("FAIL t1_exec_rd got v=%b d=%o want v=1 d=7402", exec_rd_valid, exec_rd_data);
    end
  endtask

  task automatic test_wr_rd_same();
    repeat (2) tick();
    exec_wr_req = 1; exec_wr_addr = 12'o300; exec_wr_data = 12'o1234;
    ifu_rd_req = 1; ifu_rd_addr = 12'o300;
    tick();
    exec_wr_req = 0; ifu_rd_req = 0;
    tests++;
    if ({exec_wr_ack, ifu_rd_valid} !== 2'b10) begin
      fails++; $display("FAIL t2_cycle1 got ack,valid=%b want 10", {exec_wr_ack, ifu_rd_valid});
    end
    tick();
    tests++;
    if ({exec_wr_ack, ifu_rd_valid} !== 2'b01) begin
      fails++; $display("FAIL t2_cycle2 got ack,valid=%b want 01", {exec_wr_ack, ifu_rd_valid});
    end
    tests++;
    if (ifu_rd_data !== 12'o1234) begin fails++; $display("FAIL t2_new_data got %o want 1234", ifu_rd_data); end
  endtask

  task automatic test_all_three();
    repeat (2) tick();
    wr1(12'o400, 12'o5555);
    repeat (2) tick();
    exec_wr_req = 1; exec_wr_addr = 12'o401; exec_wr_data = 12'o0777;
    exec_rd_req = 1; exec_rd_addr = 12'o400;
    ifu_rd_req = 1; ifu_rd_addr = 12'o401;
    tick();
    exec_wr_req = 0; exec_rd_req = 0; ifu_rd_req = 0;
    tests++;
    if ({exec_wr_ack, exec_rd_valid, ifu_rd_valid, mem_busy} !== 4'b1001) begin
      fails++; $display("FAIL t3_c1 got ack,erd,ifu,busy=%b want 1001",
                        {exec_wr_ack, exec_rd_valid, ifu_rd_valid, mem_busy});
    end
    tests++;
    if (dut.state !== SERVE) begin fails++; $display("FAIL t3_state_c1 got %0d want SERVE", dut.state); end
    tick();
    tests++;
    if ({exec_wr_ack, exec_rd_valid, ifu_rd_valid} !== 3'b010 || exec_rd_data !== 12'o5555) begin
      fails++; $display("FAIL t3_c2 got ack,erd,ifu=%b d=%o want 010 d=5555",
                        {exec_wr_ack, exec_rd_valid, ifu_rd_valid}, exec_rd_data);
    end
    tests++;
    if (dut.state !== BACKLOG) begin fails++; $display("FAIL t3_backlog got %0d want BACKLOG", dut.state); end
    tick();
    tests++;
    if ({exec_rd_valid, ifu_rd_valid, mem_busy} !== 3'b011 || ifu_rd_data !== 12'o0777) begin
      fails++; $display("FAIL t3_c3 got erd,ifu,busy=%b d=%o want 011 d=0777",
                        {exec_rd_valid, ifu_rd_valid, mem_busy}, ifu_rd_data);
    end
    tick();
    tests++;
    if ({ifu_rd_valid, mem_busy} !== 2'b00) begin
      fails++; $display("FAIL t3_busy_drop got ifu,busy=%b want 00", {ifu_rd_valid, mem_busy});
    end
    tick();
    tests++;
    if (dut.state !== IDLE) begin fails++; $display("FAIL t3_idle got %0d want IDLE", dut.state); end
  endtask

  task automatic test_back_to_back();
    repeat (2) tick();
    exec_wr_req = 1; exec_wr_addr = 12'o500; exec_wr_data = 12'o0011;
    ifu_rd_req = 1; ifu_rd_addr = 12'o200;
    tick();
    exec_wr_req = 0;
    ifu_rd_addr = 12'o500;
    tests++;
    if ({exec_wr_ack, ifu_rd_valid} !== 2'b10) begin
      fails++; $display("FAIL t4_c1 got ack,ifu=%b want 10", {exec_wr_ack, ifu_rd_valid});
    end
    tick();
    ifu_rd_req = 0;
    tests++;
    if ({ifu_rd_valid, ifu_rd_data} !== {1'b1, 12'o7402}) begin
      fails++; $display("FAIL t4_first got v=%b d=%o want v=1 d=7402", ifu_rd_valid, ifu_rd_data);
    end
    tick();
    tests++;
    if ({ifu_rd_valid, ifu_rd_data} !== {1'b1, 12'o0011}) begin
      fails++; $display("FAIL t4_second got v=%b d=%o want v=1 d=0011", ifu_rd_valid, ifu_rd_data);
    end
    tests++;
    if (mem_ovf !== 1'b0) begin fails++; $display("FAIL t4_no_ovf got %b want 0", mem_ovf); end
  endtask

  task automatic test_overflow();
    repeat (2) tick();
    exec_wr_req = 1; exec_wr_addr = 12'o600; exec_wr_data = 12'o0042;
    exec_rd_req = 1; exec_rd_addr = 12'o500;
    ifu_rd_req = 1; ifu_rd_addr = 12'o200;
    tick();
    exec_wr_req = 0; exec_rd_req = 0;
    ifu_rd_addr = 12'o201;
    tests++;
    if (mem_ovf !== 1'b0) begin fails++; $display("FAIL t5_pre_ovf got %b want 0", mem_ovf); end
    tick();
    ifu_rd_req = 0;
    tests++;
    if ({mem_ovf, exec_rd_valid, exec_rd_data} !== {2'b11, 12'o0011}) begin
      fails++; $display("FAIL t5_ovf got ovf=%b erd=%b d=%o want 1 1 0011", mem_ovf, exec_rd_valid, exec_rd_data);
    end
    tick();
    tests++;
    if ({ifu_rd_valid, ifu_rd_data} !== {1'b1, 12'o7402}) begin
      fails++; $display("FAIL t5_kept got v=%b d=%o want v=1 d=7402", ifu_rd_valid, ifu_rd_data);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({ifu_rd_valid, mem_ovf} !== 2'b01) begin
        fails++; $display("FAIL t5_sticky cyc%0d got valid,ovf=%b want 01", i, {ifu_rd_valid, mem_ovf});
      end
    end
    reset_n = 1;
    tick();
    reset_n = 0;
    tests++;
    if (mem_ovf !== 1'b0) begin fails++; $display("FAIL t5_ovf_reset got %b want 0", mem_ovf); end
    tick();
  endtask

  task automatic test_reset_inflight();
    l3_ewr_req = 1; l3_ewr_addr = 12'o700; l3_ewr_data = 12'o4321;
    tick();
    l3_ewr_req = 0;
    tick();
    l3_ifu_req = 1; l3_ifu_addr = 12'o700;
    tick();
    l3_ifu_req = 0;
    for (int i = 1; i < 3; i++) begin
      tests++;
      if (l3_ifu_valid !== 1'b0) begin fails++; $display("FAIL t6_early cyc%0d got %b want 0", i, l3_ifu_valid); end
      tick();
    end
    tests++;
    if ({l3_ifu_valid, l3_ifu_data} !== {1'b1, 12'o4321}) begin
      fails++; $display("FAIL t6_lat3 got v=%b d=%o want v=1 d=4321", l3_ifu_valid, l3_ifu_data);
    end
    tick();
    l3_erd_req = 1; l3_erd_addr = 12'o700;
    tick();
    l3_erd_req = 0;
    tick();
    reset_n = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (l3_erd_valid !== 1'b0) begin fails++; $display("FAIL t6_in_reset cyc%0d got %b want 0", i, l3_erd_valid); end
    end
    reset_n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if ({l3_erd_valid, l3_ifu_valid, l3_busy} !== 3'b000) begin
        fails++; $display("FAIL t6_dropped cyc%0d got erd,ifu,busy=%b want 000", i, {l3_erd_valid, l3_ifu_valid, l3_busy});
      end
    end
    tests++;
    if (l3_erd_data !== 12'o0) begin fails++; $display("FAIL t6_no_data got %o want 0", l3_erd_data); end
    l3_erd_req = 1;
    tick();
    l3_erd_req = 0;
    repeat (2) tick();
    tests++;
    if ({l3_erd_valid, l3_erd_data} !== {1'b1, 12'o4321}) begin
      fails++; $display("FAIL t6_survive got v=%b d=%o want v=1 d=4321", l3_erd_valid, l3_erd_data);
    end
  endtask

  task automatic test_parity();
    repeat (2) tick();
`ifdef MEM_PARITY_EN
    dut.mem[12'o200][12] = ~dut.mem[12'o200][12];
`endif
    ifu_rd_req = 1; ifu_rd_addr = 12'o200;
    tick();
    ifu_rd_req = 0;
    tests++;
    if ({ifu_rd_valid, ifu_rd_data} !== {1'b1, 12'o7402}) begin
      fails++; $display("FAIL t7_par_data got v=%b d=%o want v=1 d=7402", ifu_rd_valid, ifu_rd_data);
    end
`ifdef MEM_PARITY_EN
    tests++;
    if (mem_par_err !== 1'b1) begin fails++; $display("FAIL t7_par_err got %b want 1", mem_par_err); end
`else
    tests++;
    if (mem_par_err !== 1'b0) begin fails++; $display("FAIL t7_par_tied got %b want 0", mem_par_err); end
`endif
    exec_rd_req = 1; exec_rd_addr = 12'o300;
    tick();
    exec_rd_req = 0;
    tests++;
    if ({exec_rd_valid, mem_par_err, exec_rd_data} !== {2'b10, 12'o1234}) begin
      fails++; $display("FAIL t7_clean got v=%b perr=%b d=%o want 1 0 1234", exec_rd_valid, mem_par_err, exec_rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_uncontended();
    test_wr_rd_same();
    test_all_three();
    test_back_to_back();
    test_overflow();
    test_parity();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
